// File: rtl/buffer_pixeles_pkg.sv
// buffer_pixeles_pkg
// Shared constants for the pixel buffer: default parameter values, the
// pixel emission order constants, error bit positions and a width helper.
package buffer_pixeles_pkg;

  localparam int DEF_PIXEL_WIDTH     = 8;
  localparam int DEF_PIXELS_PER_WORD = 4;
  localparam int DEF_DEPTH           = 4;

  // Pixel emission order within a memory word.
  localparam int ORDER_LSB_FIRST = 0;
  localparam int ORDER_MSB_FIRST = 1;

  // Bit positions of the optional sticky error flags.
  localparam int ERR_DROP_BIT     = 0;  // write attempted while full
  localparam int ERR_UNDERRUN_BIT = 1;  // read attempted while empty

  // Index/pointer width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buffer_pixeles_word_fifo.sv
// buffer_pixeles_word_fifo
// Circular word store for the pixel buffer. Holds up to DEPTH words, exposes
// the head word combinationally (show-ahead) and keeps the word count.
// Push/pop requests are qualified here: a push while full or a pop while
// empty is ignored, and flush wins over both.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   flush           synchronous clear of pointers and count
//   push, push_data request to append a word
//   pop             request to drop the head word
//   head_data       current head word (undefined content when empty)
//   word_count      number of stored words
//   full, empty     occupancy flags derived from word_count
module buffer_pixeles_word_fifo
  import buffer_pixeles_pkg::*;
#(
  parameter int WORD_W = DEF_PIXEL_WIDTH * DEF_PIXELS_PER_WORD,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head_data,
  output logic [CNT_W-1:0]  word_count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = idx_width(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (word_count == CNT_W'(DEPTH));
  assign empty = (word_count == '0);

  // Acceptance uses the pre-edge full flag: a pop in the same cycle does not
  // open a slot for a simultaneous push.
  assign push_ok = push & ~full  & ~flush;
  assign pop_ok  = pop  & ~empty & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   word_count <= word_count + CNT_W'(1);
        2'b01:   word_count <= word_count - CNT_W'(1);
        default: word_count <= word_count;
      endcase
    end
  end

  // Storage needs no reset: content is only observed while word_count != 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/buffer_pixeles_param.sv
// buffer_pixeles_param
// Converts memory words into a stream of pixels. Words are queued in a small
// circular store; the head word is sliced into PIXELS_PER_WORD pixels that
// are presented show-ahead and consumed one per read_pixel.
//
// Optional feature: define BUFFER_PIXELES_ERR_EN to add the sticky 2-bit
// error output (bit0 = write dropped while full, bit1 = read while empty).
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   memory_data      incoming word, stored when save_mem_data and space
//   save_mem_data    write strobe
//   read_pixel       consume the current pixel
//   flush            synchronous clear, priority over write and read
//   pixel            current head pixel (0 when no data)
//   space_available  at least one free word entry
//   data_available   pixel is valid
//   word_count       stored words, including a partially consumed head
//   error            (BUFFER_PIXELES_ERR_EN only) sticky error flags
module buffer_pixeles_param
  import buffer_pixeles_pkg::*;
#(
  parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
  parameter int PIXELS_PER_WORD = DEF_PIXELS_PER_WORD,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int MSB_FIRST       = ORDER_MSB_FIRST
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] memory_data,
  input  logic                                   save_mem_data,
  input  logic                                   read_pixel,
  input  logic                                   flush,
  output logic [PIXEL_WIDTH-1:0]                 pixel,
  output logic                                   space_available,
  output logic                                   data_available,
`ifdef BUFFER_PIXELES_ERR_EN
  output logic [1:0]                             error,
`endif
  output logic [$clog2(DEPTH+1)-1:0]             word_count
);

  localparam int WORD_W = PIXEL_WIDTH * PIXELS_PER_WORD;
  localparam int IDX_W  = idx_width(PIXELS_PER_WORD);

  logic [WORD_W-1:0]      head_word;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [IDX_W-1:0]       pix_idx;
  logic [IDX_W-1:0]       lane;
  logic                   last_pixel;
  logic                   rd_fire;
  logic                   pop_word;
  logic [PIXEL_WIDTH-1:0] lanes [PIXELS_PER_WORD];

  buffer_pixeles_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_word_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (save_mem_data),
    .push_data  (memory_data),
    .pop        (pop_word),
    .head_data  (head_word),
    .word_count (word_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign space_available = ~fifo_full;
  assign data_available  = ~fifo_empty;

  assign last_pixel = (pix_idx == IDX_W'(PIXELS_PER_WORD - 1));
  assign rd_fire    = read_pixel & data_available & ~flush;
  assign pop_word   = rd_fire & last_pixel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_idx <= '0;
    end else if (flush) begin
      pix_idx <= '0;
    end else if (rd_fire) begin
      pix_idx <= last_pixel ? '0 : pix_idx + IDX_W'(1);
    end
  end

  // Lane 0 is the least significant pixel of the word.
  always_comb begin
    for (int i = 0; i < PIXELS_PER_WORD; i++) begin
      lanes[i] = head_word[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  assign lane = (MSB_FIRST != ORDER_LSB_FIRST)
              ? IDX_W'(PIXELS_PER_WORD - 1) - pix_idx
              : pix_idx;

  // Gated so the unreset storage never leaks onto pixel when empty.
  assign pixel = data_available ? lanes[lane] : '0;

`ifdef BUFFER_PIXELES_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= '0;
    end else if (flush) begin
      error <= '0;
    end else begin
      if (save_mem_data && fifo_full)     error[ERR_DROP_BIT]     <= 1'b1;
      if (read_pixel && !data_available)  error[ERR_UNDERRUN_BIT] <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/buffer_pixeles_param.md
BUFFER_PIXELES_PARAM -- requirements
Module: buffer_pixeles_param

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8: bits per pixel.
REQ-002 SHALL have parameter PIXELS_PER_WORD, default 4: pixels per memory word; memory word width is PIXEL_WIDTH*PIXELS_PER_WORD.
REQ-003 SHALL have parameter DEPTH, default 4: word storage entries; power of two, at least 2.
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 emits the most significant pixel first, 0 the least significant first.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port memory_data, input, PIXEL_WIDTH*PIXELS_PER_WORD bits: word from memory.
REQ-008 SHALL have port save_mem_data, input, 1 bit: write strobe for memory_data.
REQ-009 SHALL have port read_pixel, input, 1 bit: consume the current pixel.
REQ-010 SHALL have port flush, input, 1 bit: synchronous clear of all buffered data.
REQ-011 SHALL have port pixel, output, PIXEL_WIDTH bits: current head pixel.
REQ-012 SHALL have port space_available, output, 1 bit: at least one free word entry.
REQ-013 SHALL have port data_available, output, 1 bit: pixel is valid.
REQ-014 SHALL have port word_count, output, $clog2(DEPTH+1) bits: number of stored words, including a partially consumed head word.

Function
REQ-015 SHALL store memory_data at the edge where save_mem_data=1 and space_available=1; otherwise the word is dropped and state is unchanged.
REQ-016 SHALL present pixel show-ahead from the head word and pixel index, with no register stage between storage and pixel.
REQ-017 SHALL assert data_available in the cycle after the edge that writes a word into an empty buffer; latency is 1 cycle.
REQ-018 SHALL advance the pixel index at each edge where read_pixel=1 and data_available=1; read_pixel while data_available=0 is ignored.
REQ-019 SHALL pop the head word and reset the index to 0 when the last pixel (index PIXELS_PER_WORD-1) is read.
REQ-020 SHALL use circular pointers that wrap from DEPTH-1 to 0.
REQ-021 SHALL handle a simultaneous accepted write and pop: word_count is unchanged.
REQ-022 SHALL judge acceptance on the pre-edge space_available when full: a write coinciding with a pop is not accepted (no bypass).
REQ-023 SHALL give flush=1 priority over save_mem_data and read_pixel: the buffer empties and the index clears at that edge.
REQ-024 SHALL drive space_available = (word_count < DEPTH) and data_available = (word_count != 0).

Reset
REQ-025 SHALL, while reset=0 and independently of clk: clear pointers, index and word_count, drive pixel to 0, data_available to 0 and space_available to 1.
REQ-026 SHALL make reset asserted mid-word discard every partially consumed word.

Configuration
REQ-027 SHALL, with BUFFER_PIXELES_ERR_EN defined, add output error, 2 bits, sticky: bit0 records a dropped write when full, bit1 records a read when empty; cleared by reset or flush.
REQ-028 SHALL, without BUFFER_PIXELES_ERR_EN, have no error port and no error logic.

Structure
REQ-029 SHALL take default parameter values and the MSB_FIRST/LSB_FIRST order constants from package buffer_pixeles_pkg.
REQ-030 SHALL implement word storage, pointers and word_count in sub-module buffer_pixeles_word_fifo; pixel indexing and selection stay in the top level.

Verification
REQ-031 SHALL cover: reset release, then one write of 32'haabbccdd with MSB_FIRST=1 -> data_available=1 one cycle later, and four reads give pixel aa, bb, cc, dd, then data_available=0.
REQ-032 SHALL cover: the same word with MSB_FIRST=0 -> pixels dd, cc, bb, aa.
REQ-033 SHALL cover: 5 writes with DEPTH=4 (12345678, 87654321, abcdef77, 01020304, 55667788) -> space_available=0 after the 4th, the 5th is dropped, error[0]=1 with the macro defined, and 16 pixels are read in order ending 01020304.
REQ-034 SHALL cover: buffer full, pop of the last head pixel together with save_mem_data -> write rejected, word_count=3 next cycle.
REQ-035 SHALL cover: two words stored, one pixel read, flush=1 together with save_mem_data=1 -> word_count=0, data_available=0, written word discarded.
REQ-036 SHALL cover: reset driven low between clock edges mid-word -> outputs reach reset values immediately, with no wait for the next edge.
